// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder with add, subtract and accumulate
// modes. Stage 1 computes both candidate sums of every BLOCK-wide slice
// (slice carry-in 0 and 1). Stage 2 resolves the slice-to-slice select chain
// and registers sum, carry-out and signed overflow. Both stages use a
// valid/ready handshake, so the pipeline can stall under backpressure.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB = WIDTH / BLOCK;

  typedef enum logic [1:0] {
    MODE_ADD     = 2'b00,
    MODE_SUB     = 2'b01,
    MODE_ACC     = 2'b10,
    MODE_ADD_ALT = 2'b11
  } mode_e;

  // Reject illegal geometries when the design is elaborated.
  if ((WIDTH % BLOCK) != 0 || WIDTH < 8 || WIDTH > 64 || BLOCK < 1) begin : g_param_check
    $error("csel_adder_pipe: WIDTH must be 8..64 and a multiple of BLOCK");
  end

  // Effective operands presented to stage 1.
  logic [WIDTH-1:0] x_eff;
  logic [WIDTH-1:0] y_eff;
  logic             c0_eff;
  logic             is_acc;

  // Candidate slice sums and carries for slice carry-in 0 and 1.
  logic [NB-1:0][BLOCK-1:0] cand_sum0;
  logic [NB-1:0][BLOCK-1:0] cand_sum1;
  logic [NB-1:0]            cand_co0;
  logic [NB-1:0]            cand_co1;

  // Stage 1 registers.
  logic                     s1_valid;
  logic [NB-1:0][BLOCK-1:0] s1_sum0;
  logic [NB-1:0][BLOCK-1:0] s1_sum1;
  logic [NB-1:0]            s1_co0;
  logic [NB-1:0]            s1_co1;
  logic                     s1_c0;
  logic                     s1_x_msb;
  logic                     s1_y_msb;
  logic                     s1_acc_op;

  // Stage 2 resolution results (combinational, from stage 1 registers).
  logic [NB-1:0][BLOCK-1:0] res_sum;
  logic                     res_cout;
  logic                     res_ovf;
  logic                     carry;

  // Accumulator and handshake control.
  logic [WIDTH-1:0] acc;
  logic             s2_valid;
  logic             s2_load_en;
  logic             s1_advance;
  logic             s1_can_load;
  logic             acc_hazard;
  logic             accept;

  // Handshake: a stage loads when empty or when its contents leave this cycle.
  assign s2_load_en  = !s2_valid || out_ready;
  assign s1_advance  = s1_valid && s2_load_en;
  assign s1_can_load = !s1_valid || s1_advance;
  // An accumulate op must not read acc until the one ahead of it has written it.
  assign acc_hazard  = (mode_e'(mode) == MODE_ACC) && s1_valid && s1_acc_op;
  assign in_ready    = s1_can_load && !acc_hazard;
  assign accept      = in_valid && in_ready;
  assign out_valid   = s2_valid;

  // Select effective operands X, Y and carry-in from the requested mode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    x_eff  = a;
    y_eff  = b;
    c0_eff = cin;
    is_acc = 1'b0;
    case (mode_e'(mode))
      MODE_SUB: begin
        y_eff  = ~b;
        c0_eff = 1'b1;
      end
      MODE_ACC: begin
        x_eff  = acc;
        is_acc = 1'b1;
      end
      default: ;
    endcase
  end

  // Compute both candidate sums for every slice.
  always_comb begin
    cand_sum0 = '0;
    cand_sum1 = '0;
    cand_co0  = '0;
    cand_co1  = '0;
    for (int i = 0; i < NB; i++) begin
      {cand_co0[i], cand_sum0[i]} = {1'b0, x_eff[i*BLOCK +: BLOCK]}
                                  + {1'b0, y_eff[i*BLOCK +: BLOCK]};
      {cand_co1[i], cand_sum1[i]} = {1'b0, x_eff[i*BLOCK +: BLOCK]}
                                  + {1'b0, y_eff[i*BLOCK +: BLOCK]}
                                  + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  // Stage 1 valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_can_load) begin
      s1_valid <= accept;
    end
  end

  // Stage 1 payload capture on acceptance.
  // NOTE: payload registers carry no reset; they are qualified by s1_valid, so their power-up value is never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sum0   <= cand_sum0;
      s1_sum1   <= cand_sum1;
      s1_co0    <= cand_co0;
      s1_co1    <= cand_co1;
      s1_c0     <= c0_eff;
      s1_x_msb  <= x_eff[WIDTH-1];
      s1_y_msb  <= y_eff[WIDTH-1];
      s1_acc_op <= is_acc;
    end
  end

  // Resolve the carry-select chain slice by slice and derive overflow.
  always_comb begin
    // NOTE: carry is a blocking temporary so each slice sees the carry chosen by the slice below it.
    carry   = s1_c0;
    res_sum = '0;
    for (int i = 0; i < NB; i++) begin
      res_sum[i] = carry ? s1_sum1[i] : s1_sum0[i];
      carry      = carry ? s1_co1[i]  : s1_co0[i];
    end
    res_cout = carry;
    res_ovf  = (s1_x_msb == s1_y_msb) && (res_sum[NB-1][BLOCK-1] != s1_x_msb);
  end

  // Stage 2 result registers; they hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_load_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= res_sum;
        cout <= res_cout;
        ovf  <= res_ovf;
      end
    end
  end

  // Accumulator: clear wins over an accumulate result entering stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (s1_advance && s1_acc_op) begin
      acc <= res_sum;
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Self-checking bench for csel_adder_pipe: directed cases on a 16/4 instance,
// plus randomized valid/ready regressions on several WIDTH/BLOCK geometries
// checked against a plain-arithmetic reference model.
module tb_csel_adder_pipe;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  localparam int N_RAND = 2000;

  logic clk;
  logic rst_n;
  logic rand_rst_n;

  int checks = 0;
  int errors = 0;

  // Directed-test instance signals (WIDTH=16, BLOCK=4).
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [1:0]  mode;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result of X + Y + c0 at width w, from the mode rules.
  function automatic res_t ref_add(input int w, input logic [1:0] md, input logic [63:0] av,
                                   input logic [63:0] bv, input logic c, input logic [63:0] accv);
    logic [64:0] mask;
    logic [64:0] x;
    logic [64:0] y;
    logic [64:0] full;
    logic        c0;
    res_t        r;
    mask = (65'd1 << w) - 65'd1;
    x    = {1'b0, av} & mask;
    y    = {1'b0, bv} & mask;
    c0   = c;
    if (md == 2'b01) begin
      y  = ~{1'b0, bv} & mask;
      c0 = 1'b1;
    end else if (md == 2'b10) begin
      x  = {1'b0, accv} & mask;
    end
    full   = x + y + {64'd0, c0};
    r.sum  = full[63:0] & mask[63:0];
    r.cout = full[w];
    r.ovf  = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]);
    return r;
  endfunction

  function automatic int cfg_w(input int k);
    case (k)
      0: return 8;
      1: return 8;
      2: return 16;
      3: return 32;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_b(input int k);
    case (k)
      0: return 2;
      1: return 8;
      2: return 4;
      3: return 2;
      default: return 8;
    endcase
  endfunction

  // Randomized regression instances, each with its own stimulus and model.
  for (genvar g = 0; g < 5; g++) begin : g_rand
    localparam int W = cfg_w(g);
    localparam int B = cfg_b(g);

    logic         r_in_valid;
    logic         r_in_ready;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_cin;
    logic [1:0]   r_mode;
    logic         r_acc_clr;
    logic         r_out_valid;
    logic         r_out_ready;
    logic [W-1:0] r_sum;
    logic         r_cout;
    logic         r_ovf;
    logic         done;

    csel_adder_pipe #(.WIDTH(W), .BLOCK(B)) u_dut (
      .clk       (clk),
      .rst_n     (rand_rst_n),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .a         (r_a),
      .b         (r_b),
      .cin       (r_cin),
      .mode      (r_mode),
      .acc_clr   (r_acc_clr),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready),
      .sum       (r_sum),
      .cout      (r_cout),
      .ovf       (r_ovf)
    );

    initial begin : drive
      res_t         e;
      res_t         exp_q[$];
      logic [63:0]  m_acc;
      bit           stalled;
      logic [W-1:0] p_sum;
      logic         p_cout;
      logic         p_ovf;
      int           ph;
      done        = 1'b0;
      r_in_valid  = 1'b0;
      r_a         = '0;
      r_b         = '0;
      r_cin       = 1'b0;
      r_mode      = 2'b00;
      r_acc_clr   = 1'b0;
      r_out_ready = 1'b1;
      m_acc       = '0;
      stalled     = 1'b0;
      p_sum       = '0;
      p_cout      = 1'b0;
      p_ovf       = 1'b0;
      wait (rand_rst_n === 1'b1);
      for (int cyc = 0; cyc < N_RAND + 12; cyc++) begin
        @(negedge clk);
        ph        = cyc % 200;
        r_acc_clr = 1'b0;
        if (cyc >= N_RAND || ph >= 196) begin
          // Drain the pipeline, then clear the accumulator while idle.
          r_in_valid  = 1'b0;
          r_out_ready = 1'b1;
          r_acc_clr   = (cyc < N_RAND) && (ph == 199);
        end else begin
          r_in_valid  = ($urandom_range(0, 3) != 0);
          r_mode      = 2'($urandom);
          r_a         = W'($urandom);
          r_b         = W'($urandom);
          r_cin       = 1'($urandom);
          r_out_ready = ($urandom_range(0, 3) != 0);
        end
        #1;
        if (stalled) begin
          check($sformatf("r%0d_hold_valid", g), 64'(r_out_valid), 64'd1);
          check($sformatf("r%0d_hold_sum", g), 64'(r_sum), 64'(p_sum));
          check($sformatf("r%0d_hold_cout", g), 64'(r_cout), 64'(p_cout));
          check($sformatf("r%0d_hold_ovf", g), 64'(r_ovf), 64'(p_ovf));
        end
        if (r_out_valid && r_out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("r%0d_extra_beat", g), 64'(r_out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("r%0d_sum", g), 64'(r_sum), e.sum);
            check($sformatf("r%0d_cout", g), 64'(r_cout), 64'(e.cout));
            check($sformatf("r%0d_ovf", g), 64'(r_ovf), 64'(e.ovf));
          end
        end
        stalled = r_out_valid && !r_out_ready;
        p_sum   = r_sum;
        p_cout  = r_cout;
        p_ovf   = r_ovf;
        if (r_in_valid && r_in_ready) begin
          e = ref_add(W, r_mode, 64'(r_a), 64'(r_b), r_cin, m_acc);
          exp_q.push_back(e);
          if (r_mode == 2'b10) m_acc = e.sum;
        end
        if (r_acc_clr) m_acc = '0;
      end
      check($sformatf("r%0d_lost_beats", g), 64'(exp_q.size()), 64'd0);
      done = 1'b1;
    end
  end

  logic all_done;
  assign all_done = g_rand[0].done && g_rand[1].done && g_rand[2].done
                 && g_rand[3].done && g_rand[4].done;

  // One isolated beat: accepted, absent one cycle later, present the next.
  task automatic run_single(input string tag, input logic [1:0] md, input logic [15:0] av,
                            input logic [15:0] bv, input logic c, input logic [15:0] es,
                            input logic ec, input logic eo);
    @(negedge clk);
    in_valid  = 1'b1;
    mode      = md;
    a         = av;
    b         = bv;
    cin       = c;
    out_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  // Cycle bound so the bench always ends on its own.
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] ba[3];
    logic [15:0] bb[3];
    res_t        bexp[3];
    logic [15:0] acc_got[$];
    int          exp_rdy[5];
    int          acc_n;
    int          idx;
    int          n_out;
    ba      = '{16'h1111, 16'h3333, 16'h8000};
    bb      = '{16'h2222, 16'h4444, 16'h8000};
    exp_rdy = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 3; i++) bexp[i] = ref_add(16, 2'b00, 64'(ba[i]), 64'(bb[i]), 1'b0, 64'd0);

    rst_n      = 1'b0;
    rand_rst_n = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    mode       = 2'b00;
    acc_clr    = 1'b0;
    out_ready  = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n      = 1'b1;
    rand_rst_n = 1'b1;

    // Add / subtract corner cases.
    run_single("add_carry_ripple", 2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_single("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("add_ovf", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_single("sub_borrow", 2'b01, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_single("sub_ovf", 2'b01, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_single("add_cin", 2'b00, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_single("mode11_add", 2'b11, 16'h1000, 16'h0234, 1'b1, 16'h1235, 1'b0, 1'b0);

    // Accumulate chain with RAW stall.
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    acc_n   = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      in_valid = (acc_n < 3);
      mode     = 2'b10;
      a        = 16'hDEAD;
      b        = 16'h0005;
      cin      = 1'b0;
      #1;
      if (cyc < 5) check($sformatf("acc_ready_c%0d", cyc), 64'(in_ready), 64'(exp_rdy[cyc]));
      if (in_valid && in_ready) acc_n++;
      if (out_valid) acc_got.push_back(sum);
    end
    check("acc_count", 64'(acc_got.size()), 64'd3);
    for (int i = 0; i < 3 && i < acc_got.size(); i++)
      check($sformatf("acc_res%0d", i), 64'(acc_got[i]), 64'(5 * (i + 1)));

    // Backpressure: two beats accepted, third held off, output stable.
    idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (idx < 3);
      mode      = 2'b00;
      cin       = 1'b0;
      if (idx < 3) begin
        a = ba[idx];
        b = bb[idx];
      end
      #1;
      if (cyc == 3) begin
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_hold_sum", 64'(sum), bexp[0].sum);
      end
      if (in_valid && in_ready) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    n_out = 0;
    for (int cyc = 0; cyc < 10 && n_out < 3; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 3);
      if (idx < 3) begin
        a = ba[idx];
        b = bb[idx];
      end
      #1;
      if (out_valid) begin
        check($sformatf("bp_sum%0d", n_out), 64'(sum), bexp[n_out].sum);
        check($sformatf("bp_cout%0d", n_out), 64'(cout), 64'(bexp[n_out].cout));
        check($sformatf("bp_ovf%0d", n_out), 64'(ovf), 64'(bexp[n_out].ovf));
        n_out++;
      end
      if (in_valid && in_ready) idx++;
    end
    check("bp_drained", 64'(n_out), 64'd3);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset with two beats in flight; acc currently 15.
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 2'b00;
    a        = 16'hFFFF;
    b        = 16'h0002;
    cin      = 1'b0;
    @(negedge clk);
    a = 16'h1234;
    b = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("inflight_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_sum", 64'(sum), 64'd0);
    check("arst_cout", 64'(cout), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("arst_hold_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_single("post_rst_acc", 2'b10, 16'h0000, 16'h0003, 1'b0, 16'h0003, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("post_rst_no_stale", 64'(out_valid), 64'd0);

    // Wait for the random regressions, bounded.
    for (int i = 0; i < 6000 && !all_done; i++) @(negedge clk);
    check("rand_done", 64'(all_done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
